fp_result_checker: RTL and testbench
====================================

// Module: fp_result_checker
// PURPOSE
//  Synthesizable scoreboard downstream of fp_unit. Buffers expected result/flags vectors in a FIFO,
//  pairs each with the next fp_unit result in order, and compares them with canonical-NaN masking.
//  Counts passes, latches the first mismatch and reports pass/fail/done status to the test harness.
// PARAMETERS
//  DEPTH  16  expected-vector FIFO entries; power of two, >=2
//  CNT_W  32  width of pass counter and vector index
// PORTS
//  clock            in   1      system clock
//  reset            in   1      asynchronous, active-low reset
//  start            in   1      pulse: clear counters/FIFO/latches and enter RUN
//  finish           in   1      pulse: no further expected vectors; go DONE once drained
//  exp_valid        in   1      expected vector present
//  exp_ready        out  1      FIFO can accept (= RUN and not full)
//  exp_result       in   64     reference result
//  exp_flags        in   5      reference exception flags (NV,DZ,OF,UF,NX)
//  exp_fmt          in   2      0 = single, 1 = double
//  exp_isfp         in   1      1 = FP-valued result (NaN masking allowed); 0 = fcmp/fcvt_f2i
//  res_valid        in   1      fp_unit result valid (fp_exe_o.ready)
//  res_result       in   64     fp_unit result
//  res_flags        in   5      fp_unit flags
//  busy             out  1      state == RUN
//  done             out  1      state == DONE
//  fail             out  1      state == FAIL
//  err_code         out  2      0 none, 1 mismatch, 2 underflow (result with empty FIFO)
//  pass_count       out  CNT_W  matched vectors, saturating
//  fail_index       out  CNT_W  zero-based index of failing vector
//  fail_ref         out  64     latched reference result
//  fail_calc        out  64     latched calculated result
//  fail_flags_ref   out  5      latched reference flags
//  fail_flags_calc  out  5      latched calculated flags
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, FIFO empty, all outputs 0.
//  - States: IDLE -start-> RUN; RUN -mismatch/underflow-> FAIL; RUN -finish or pending_finish, FIFO empty,
//    no compare in flight-> DONE; FAIL and DONE are sticky; start from any state -> RUN (clears everything).
//  - start has priority over every other event in the same cycle; that cycle's push/pop are dropped.
//  - Push when exp_valid & exp_ready. Full -> exp_ready=0, no overwrite. exp_valid outside RUN ignored.
//  - Pop when res_valid in RUN; head fields registered into compare stage with res_*; compare result
//    acts one cycle later (latency 1): pass_count++ or FAIL entered on the following edge.
//  - res_valid with FIFO empty (no same-cycle bypass of a push) -> underflow: err_code=2, FAIL, fail_index=count.
//  - res_valid outside RUN ignored. Push and pop in same cycle: both occur, occupancy unchanged.
//  - diff_r = exp_result ^ res_result; diff_f = exp_flags ^ res_flags.
//  - Masking when exp_isfp=1: fmt 0 and res_result==64'h000000007FC00000 -> clear diff_r[21:0], [63:31];
//    fmt 1 and res_result==64'h7FF8000000000000 -> clear diff_r[50:0], [63]. No masking when exp_isfp=0.
//  - Mismatch = (diff_r!=0)|(diff_f!=0): err_code=1, latch fail_* from compare stage, FAIL next cycle.
//    Only first failure latched; results arriving after FAIL ignored.
//  - finish while FIFO non-empty sets pending_finish; DONE when drained and last compare passed.
//  - pass_count saturates at all-ones; fail_index/vector index wraps at 2^CNT_W.
//  - FIFO pointers carry one extra wrap bit for full/empty; wrap at DEPTH.
// STRUCTURE
//  - fp_wire package: fp_check_state_type enum (IDLE,RUN,FAIL,DONE), fp_check_err_type, canonical-NaN
//    constants, fp_check_entry struct {result,flags,fmt,isfp}.
//  - Sub-module fp_check_fifo: synchronous FIFO of fp_check_entry, DEPTH param, full/empty, async reset.
//  - Top: state register, compare stage register, masking comb logic, counters, fail latches.
// TESTING
//  - 4 vectors pushed, 4 matching results (latency 3) then finish -> pass_count=4, done=1, err_code=0.
//  - exp fmt0 isfp=1 result 0x7FC00001, calc 0x000000007FC00000, flags equal -> pass (masked).
//  - Same vector with exp_isfp=0 -> fail=1, err_code=1, fail_calc=0x000000007FC00000, fail_index=0.
//  - Flags-only diff: exp 0x3F800000/0x01, calc 0x3F800000/0x00 -> FAIL, fail_flags_ref=0x01.
//  - res_valid with empty FIFO in RUN -> err_code=2, fail=1; later results leave pass_count unchanged.
//  - Push DEPTH vectors without results -> exp_ready=0; pop one -> exp_ready=1; reset mid-RUN -> all 0.

Source files
------------

// File: rtl/fp_wire.sv
// Shared types and constants for the fp_unit result checker.
package fp_wire;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2,
    DONE = 2'd3
  } fp_check_state_type;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_MISMATCH  = 2'd1,
    ERR_UNDERFLOW = 2'd2
  } fp_check_err_type;

  localparam logic [1:0]  FMT_S       = 2'd0;
  localparam logic [1:0]  FMT_D       = 2'd1;
  localparam logic [63:0] CANON_NAN_S = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic [1:0]  fmt;
    logic        isfp;
  } fp_check_entry;

  // A canonical NaN from the unit matches any NaN payload/sign the reference produced.
  function automatic logic [63:0] fp_check_diff(input fp_check_entry e, input logic [63:0] res);
    logic [63:0] d;
    d = e.result ^ res;
    if (e.isfp && (e.fmt == FMT_S) && (res == CANON_NAN_S)) begin
      d[21:0]  = '0;
      d[63:31] = '0;
    end else if (e.isfp && (e.fmt == FMT_D) && (res == CANON_NAN_D)) begin
      d[50:0] = '0;
      d[63]   = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// Synchronous FIFO of expected vectors; pointers carry an extra wrap bit.
module fp_check_fifo
  import fp_wire::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          push_i,
  input  fp_check_entry data_i,
  input  logic          pop_i,
  output fp_check_entry data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fp_check_entry mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i && !full_o) wr_d = wr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge clock) begin
    if (!clr_i && push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fp_result_checker.sv
// In-order scoreboard: pairs fp_unit results with buffered expected vectors and latches the first miss.
module fp_result_checker
  import fp_wire::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [63:0]      exp_result,
  input  logic [4:0]       exp_flags,
  input  logic [1:0]       exp_fmt,
  input  logic             exp_isfp,
  input  logic             res_valid,
  input  logic [63:0]      res_result,
  input  logic [4:0]       res_flags,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_index,
  output logic [63:0]      fail_ref,
  output logic [63:0]      fail_calc,
  output logic [4:0]       fail_flags_ref,
  output logic [4:0]       fail_flags_calc
);

  fp_check_state_type state_q, state_d;
  fp_check_err_type   err_q, err_d;
  logic               pend_q, pend_d;
  logic               cmp_valid_q, cmp_valid_d;
  fp_check_entry      cmp_exp_q, cmp_exp_d;
  logic [63:0]        cmp_res_q, cmp_res_d;
  logic [4:0]         cmp_flags_q, cmp_flags_d;
  logic [CNT_W-1:0]   cmp_idx_q, cmp_idx_d;
  logic [CNT_W-1:0]   vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fidx_q, fidx_d;
  logic [63:0]        fref_q, fref_d;
  logic [63:0]        fcalc_q, fcalc_d;
  logic [4:0]         ffr_q, ffr_d;
  logic [4:0]         ffc_q, ffc_d;

  fp_check_entry push_data, head;
  logic          full, empty, push, pop, clr;
  logic [63:0]   diff_r;
  logic [4:0]    diff_f;
  logic          mismatch;

  assign push_data = '{result: exp_result, flags: exp_flags, fmt: exp_fmt, isfp: exp_isfp};

  fp_check_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (clr),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign diff_r   = fp_check_diff(cmp_exp_q, cmp_res_q);
  assign diff_f   = cmp_exp_q.flags ^ cmp_flags_q;
  assign mismatch = cmp_valid_q && ((diff_r != '0) || (diff_f != '0));

  assign exp_ready       = (state_q == RUN) && !full;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign fail            = (state_q == FAIL);
  assign err_code        = err_q;
  assign pass_count      = pass_q;
  assign fail_index      = fidx_q;
  assign fail_ref        = fref_q;
  assign fail_calc       = fcalc_q;
  assign fail_flags_ref  = ffr_q;
  assign fail_flags_calc = ffc_q;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    pend_d      = pend_q;
    cmp_valid_d = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_res_d   = cmp_res_q;
    cmp_flags_d = cmp_flags_q;
    cmp_idx_d   = cmp_idx_q;
    vec_idx_d   = vec_idx_q;
    pass_d      = pass_q;
    fidx_d      = fidx_q;
    fref_d      = fref_q;
    fcalc_d     = fcalc_q;
    ffr_d       = ffr_q;
    ffc_d       = ffc_q;
    push        = 1'b0;
    pop         = 1'b0;
    clr         = 1'b0;

    if (start) begin
      state_d   = RUN;
      err_d     = ERR_NONE;
      pend_d    = 1'b0;
      cmp_idx_d = '0;
      vec_idx_d = '0;
      pass_d    = '0;
      fidx_d    = '0;
      fref_d    = '0;
      fcalc_d   = '0;
      ffr_d     = '0;
      ffc_d     = '0;
      clr       = 1'b1;
    end else if (state_q == RUN) begin
      push = exp_valid && !full;
      pop  = res_valid && !empty;
      if (finish) pend_d = 1'b1;
      if (pop) begin
        cmp_valid_d = 1'b1;
        cmp_exp_d   = head;
        cmp_res_d   = res_result;
        cmp_flags_d = res_flags;
        cmp_idx_d   = vec_idx_q;
        vec_idx_d   = vec_idx_q + CNT_W'(1);
      end
      // The in-flight compare belongs to an older vector, so it outranks a new underflow.
      if (mismatch) begin
        state_d = FAIL;
        err_d   = ERR_MISMATCH;
        fidx_d  = cmp_idx_q;
        fref_d  = cmp_exp_q.result;
        fcalc_d = cmp_res_q;
        ffr_d   = cmp_exp_q.flags;
        ffc_d   = cmp_flags_q;
      end else begin
        if (cmp_valid_q && (pass_q != '1)) pass_d = pass_q + CNT_W'(1);
        if (res_valid && empty) begin
          state_d = FAIL;
          err_d   = ERR_UNDERFLOW;
          fidx_d  = vec_idx_q;
        end else if ((finish || pend_q) && empty && !cmp_valid_q && !push) begin
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      err_q       <= ERR_NONE;
      pend_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_res_q   <= '0;
      cmp_flags_q <= '0;
      cmp_idx_q   <= '0;
      vec_idx_q   <= '0;
      pass_q      <= '0;
      fidx_q      <= '0;
      fref_q      <= '0;
      fcalc_q     <= '0;
      ffr_q       <= '0;
      ffc_q       <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_res_q   <= cmp_res_d;
      cmp_flags_q <= cmp_flags_d;
      cmp_idx_q   <= cmp_idx_d;
      vec_idx_q   <= vec_idx_d;
      pass_q      <= pass_d;
      fidx_q      <= fidx_d;
      fref_q      <= fref_d;
      fcalc_q     <= fcalc_d;
      ffr_q       <= ffr_d;
      ffc_q       <= ffc_d;
    end
  end

endmodule

// File: tb/tb_fp_result_checker.sv
// Directed bench for fp_result_checker: pass path, NaN masking, mismatches, underflow, full FIFO, reset.
module tb_fp_result_checker;

  logic        clk, rst_n;
  logic        start, finish, exp_valid, exp_ready;
  logic [63:0] exp_result;
  logic [4:0]  exp_flags;
  logic [1:0]  exp_fmt;
  logic        exp_isfp;
  logic        res_valid;
  logic [63:0] res_result;
  logic [4:0]  res_flags;
  logic        busy, done, fail;
  logic [1:0]  err_code;
  logic [31:0] pass_count, fail_index;
  logic [63:0] fail_ref, fail_calc;
  logic [4:0]  fail_flags_ref, fail_flags_calc;

  int checks   = 0;
  int failures = 0;

  fp_result_checker #(.DEPTH(16), .CNT_W(32)) dut (
    .clock           (clk),
    .reset           (rst_n),
    .start           (start),
    .finish          (finish),
    .exp_valid       (exp_valid),
    .exp_ready       (exp_ready),
    .exp_result      (exp_result),
    .exp_flags       (exp_flags),
    .exp_fmt         (exp_fmt),
    .exp_isfp        (exp_isfp),
    .res_valid       (res_valid),
    .res_result      (res_result),
    .res_flags       (res_flags),
    .busy            (busy),
    .done            (done),
    .fail            (fail),
    .err_code        (err_code),
    .pass_count      (pass_count),
    .fail_index      (fail_index),
    .fail_ref        (fail_ref),
    .fail_calc       (fail_calc),
    .fail_flags_ref  (fail_flags_ref),
    .fail_flags_calc (fail_flags_calc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; tick(); finish = 1'b0;
  endtask

  task automatic push_vec(input logic [63:0] r, input logic [4:0] f, input logic [1:0] fm, input logic fp);
    exp_valid = 1'b1; exp_result = r; exp_flags = f; exp_fmt = fm; exp_isfp = fp;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic send_res(input logic [63:0] r, input logic [4:0] f);
    res_valid = 1'b1; res_result = r; res_flags = f;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; exp_valid = 1'b0; res_valid = 1'b0;
    exp_result = '0; exp_flags = '0; exp_fmt = '0; exp_isfp = 1'b0;
    res_result = '0; res_flags = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_err", 64'(err_code), 64'd0);
    chk("rst_pass", 64'(pass_count), 64'd0);
    chk("rst_ready", 64'(exp_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // Four double-precision vectors, early finish, then matching results.
    pulse_start();
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_ready", 64'(exp_ready), 64'd1);
    for (int i = 0; i < 4; i++) push_vec(64'h4000_0000_0000_0000 + 64'(i), 5'(i), 2'd1, 1'b1);
    pulse_finish();
    chk("pend_not_done", 64'(done), 64'd0);
    chk("pend_busy", 64'(busy), 64'd1);
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) send_res(64'h4000_0000_0000_0000 + 64'(i), 5'(i));
    wait_done(20);
    chk("four_pass", 64'(pass_count), 64'd4);
    chk("four_done", 64'(done), 64'd1);
    chk("four_err", 64'(err_code), 64'd0);
    chk("four_busy", 64'(busy), 64'd0);

    // Single-precision canonical NaN masks the payload difference.
    pulse_start();
    chk("restart_pass", 64'(pass_count), 64'd0);
    chk("restart_done", 64'(done), 64'd0);
    push_vec(64'h0000_0000_7FC0_0001, 5'h10, 2'd0, 1'b1);
    send_res(64'h0000_0000_7FC0_0000, 5'h10);
    tick();
    chk("nan_mask_pass", 64'(pass_count), 64'd1);
    chk("nan_mask_fail", 64'(fail), 64'd0);
    pulse_finish();
    wait_done(10);
    chk("nan_mask_done", 64'(done), 64'd1);

    // Same vector without FP masking must mismatch.
    pulse_start();
    push_vec(64'h0000_0000_7FC0_0001, 5'h10, 2'd0, 1'b0);
    send_res(64'h0000_0000_7FC0_0000, 5'h10);
    tick();
    chk("nomask_fail", 64'(fail), 64'd1);
    chk("nomask_err", 64'(err_code), 64'd1);
    chk("nomask_calc", fail_calc, 64'h0000_0000_7FC0_0000);
    chk("nomask_ref", fail_ref, 64'h0000_0000_7FC0_0001);
    chk("nomask_idx", 64'(fail_index), 64'd0);
    chk("nomask_pass", 64'(pass_count), 64'd0);

    // Flags-only mismatch on the second vector; later results ignored.
    pulse_start();
    push_vec(64'h0000_0000_3F80_0000, 5'h00, 2'd0, 1'b1);
    push_vec(64'h0000_0000_3F80_0000, 5'h01, 2'd0, 1'b1);
    send_res(64'h0000_0000_3F80_0000, 5'h00);
    send_res(64'h0000_0000_3F80_0000, 5'h00);
    tick();
    chk("flags_fail", 64'(fail), 64'd1);
    chk("flags_err", 64'(err_code), 64'd1);
    chk("flags_idx", 64'(fail_index), 64'd1);
    chk("flags_ref", 64'(fail_flags_ref), 64'h01);
    chk("flags_calc", 64'(fail_flags_calc), 64'h00);
    chk("flags_pass", 64'(pass_count), 64'd1);
    send_res(64'h0000_0000_3F80_0000, 5'h00);
    tick();
    chk("flags_after_pass", 64'(pass_count), 64'd1);

    // Underflow after one good vector.
    pulse_start();
    push_vec(64'h3FF0_0000_0000_0000, 5'h00, 2'd1, 1'b1);
    send_res(64'h3FF0_0000_0000_0000, 5'h00);
    tick();
    chk("uf_pre_pass", 64'(pass_count), 64'd1);
    send_res(64'h1234, 5'h00);
    chk("uf_fail", 64'(fail), 64'd1);
    chk("uf_err", 64'(err_code), 64'd2);
    chk("uf_idx", 64'(fail_index), 64'd1);
    send_res(64'h1234, 5'h00);
    tick();
    chk("uf_after_pass", 64'(pass_count), 64'd1);

    // Fill the FIFO, then free one slot, then reset asynchronously mid-run.
    pulse_start();
    for (int i = 0; i < 16; i++) push_vec(64'h100 + 64'(i), 5'h00, 2'd1, 1'b1);
    chk("full_ready", 64'(exp_ready), 64'd0);
    push_vec(64'hDEAD, 5'h1F, 2'd1, 1'b1);
    chk("full_still", 64'(exp_ready), 64'd0);
    send_res(64'h100, 5'h00);
    chk("pop_ready", 64'(exp_ready), 64'd1);
    tick();
    chk("pop_pass", 64'(pass_count), 64'd1);
    chk("pop_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(exp_ready), 64'd0);
    chk("mrst_pass", 64'(pass_count), 64'd0);
    chk("mrst_err", 64'(err_code), 64'd0);
    chk("mrst_fail", 64'(fail), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
